piso_serializer: RTL

Parallel-in/serial-out front end for the serial pattern-detector stage. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on ser_out, which drives the detector's serial input I directly. A one-word holding register lets a new word be accepted while the current one shifts, giving gap-free back-to-back streaming.

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_serializer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared types for the parallel-in/serial-out serializer.
//   state_t : serializer state, IDLE (nothing shifting) or SHIFT (a word is
//             on ser_out).
// The bit counter width, CNT_W = $clog2(WIDTH), depends on each instance's
// WIDTH parameter, so piso_serializer derives it locally.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: accepts WIDTH-bit words over valid/ready and emits them one
// bit per clock on ser_out, feeding the pattern detector's serial input. A
// one-word holding register lets the next word be accepted while the current
// one shifts, so back-to-back words stream without gaps.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    parallel word (WIDTH bits)
//   in_valid   in_data is valid
//   in_ready   holding register empty; accept on in_valid && in_ready
//   ser_out    serial bit (0 while idle)
//   ser_valid  ser_out carries a live bit
//   word_done  pulse coincident with the last bit of a word
//   busy       ser_valid || holding register full
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no word shifting; a full hold register is loaded next edge
// SHIFT | shift_q is on ser_out, cnt_q is the index of the bit shown
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             word_done,
   output logic             busy
);
   import piso_pkg::*;

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] hold_q;
   logic             hold_full_q;
   logic [WIDTH-1:0] shift_q;
   logic [CNT_W-1:0] cnt_q;

   logic accept;
   logic last_bit;
   logic transfer;

   // rst_n gates in_ready so nothing is offered as accepted while in reset.
   assign in_ready = !hold_full_q && rst_n;
   assign accept   = in_valid && in_ready;
   assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
   // A waiting word is loaded either from idle or exactly as the last bit of
   // the current word goes out, which is what keeps streaming gap-free.
   assign transfer = hold_full_q && ((state_q == IDLE) || last_bit);
   assign busy     = ser_valid || hold_full_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ser_valid = 1'b0;
      ser_out   = 1'b0;
      word_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (hold_full_q) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
            word_done = (cnt_q == LAST_CNT);
            if (last_bit && !hold_full_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
      end else begin
         if (accept) begin
            hold_q      <= in_data;
            hold_full_q <= 1'b1;
         end else if (transfer) begin
            hold_full_q <= 1'b0;
         end

         if (transfer) begin
            shift_q <= hold_q;
            cnt_q   <= '0;
         end else if (state_q == SHIFT) begin
            shift_q <= MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, shift_q[WIDTH-1:1]};
            // The counter only returns to 0 through a transfer; at the end
            // of an isolated word it parks at WIDTH-1 while idle.
            if (!last_bit) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end
   end

endmodule
